// File: rtl/hiscore_ram_responder.sv
// hiscore_ram_responder: pauses the CPU and borrows the work-RAM port for one hiscore access.
//   clock_18, reset                           : clock, synchronous active-high reset
//   hs_address, hs_data_in, hs_write, hs_read : hiscore engine request (single-cycle strobes)
//   hs_data_out, hs_ack, hs_busy              : read data, completion pulse, busy flag
//   pause_req, paused                         : CPU pause handshake
//   cpu_addr, cpu_din, cpu_we                 : CPU side of the RAM bus
//   ram_addr, ram_din, ram_we, ram_dout       : single-port work RAM
module hiscore_ram_responder #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 1,
    parameter int SETTLE      = 2,
    parameter int LINGER      = 16
) (
    input  logic              clock_18,
    input  logic              reset,
    input  logic [ADDR_W-1:0] hs_address,
    input  logic [DATA_W-1:0] hs_data_in,
    input  logic              hs_write,
    input  logic              hs_read,
    output logic [DATA_W-1:0] hs_data_out,
    output logic              hs_ack,
    output logic              hs_busy,
    output logic              pause_req,
    input  logic              paused,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_ACCESS, S_RWAIT, S_DONE} state_t;
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [7:0]        lcnt, lcnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q, data_q;
    logic              wr_q, owner_hs, req;
    assign req = hs_read | hs_write;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lcnt_n  = (lcnt != 8'd0) ? lcnt - 8'd1 : 8'd0;
        case (state)
            S_IDLE:   if (req) state_n = (lcnt != 8'd0 && paused) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (paused) begin
                          state_n = S_SETTLE;
                          cnt_n   = 4'(SETTLE);
                      end
            S_SETTLE: if (!paused) state_n = S_WAIT;
                      else if (cnt == 4'd1) state_n = S_ACCESS;
                      else cnt_n = cnt - 4'd1;
            S_ACCESS: if (wr_q || RAM_LATENCY == 1) state_n = S_DONE;
                      else begin
                          state_n = S_RWAIT;
                          cnt_n   = 4'(RAM_LATENCY - 1);
                      end
            S_RWAIT:  if (cnt == 4'd1) state_n = S_DONE;
                      else cnt_n = cnt - 4'd1;
            S_DONE:   begin
                          state_n = S_IDLE;
                          lcnt_n  = 8'(LINGER);
                      end
            default:  state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clock_18) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lcnt   <= '0;
            addr_q <= '0;
            din_q  <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lcnt  <= lcnt_n;
            if (state == S_IDLE && req) begin
                addr_q <= hs_address;
                din_q  <= hs_data_in;
                wr_q   <= hs_write;
            end
            if (state == S_DONE && !wr_q) data_q <= ram_dout;
        end
    end
    // The port is handed over one cycle early (last settle cycle) so the
    // address is stable before ACCESS; a pause dropout cancels the handover.
    assign owner_hs = state == S_ACCESS || state == S_RWAIT || state == S_DONE ||
                      (state == S_SETTLE && cnt == 4'd1 && paused);
    assign ram_addr = owner_hs ? addr_q : cpu_addr;
    assign ram_din  = owner_hs ? din_q : cpu_din;
    assign ram_we   = owner_hs ? (state == S_ACCESS && wr_q) : cpu_we;
    assign hs_busy  = state != S_IDLE;
    assign hs_ack   = state == S_DONE;
    // Pause stays requested while busy and through the linger window after an ack.
    assign pause_req = hs_busy || lcnt != 8'd0;
    // Read data is presented in the ack cycle straight from the RAM, then held.
    assign hs_data_out = (state == S_DONE && !wr_q) ? ram_dout : data_q;
endmodule

// File: tb/tb_hiscore_ram_responder.sv
// tb_hiscore_ram_responder: directed vector and sequence checks for hiscore_ram_responder.
module tb_hiscore_ram_responder;
    localparam logic [10:0] CPU_A = 11'h055;
    logic        clock_18 = 1'b0;
    logic        reset;
    logic [10:0] hs_address, cpu_addr;
    logic [7:0]  hs_data_in, cpu_din;
    logic        hs_write, hs_read, paused, cpu_we;
    logic [7:0]  hs_data_out, ram_din, ram_dout;
    logic        hs_ack, hs_busy, pause_req, ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  d3_dout, d3_din, d3_rdout;
    logic        d3_ack, d3_busy, d3_preq, d3_we;
    logic [10:0] d3_addr;
    logic [7:0]  mem [2048];
    logic [7:0]  mem3 [2048];
    logic [7:0]  p3 [3];
    int checks = 0;
    int errors = 0;

    always #5 clock_18 = ~clock_18;

    hiscore_ram_responder u_dut (
        .clock_18(clock_18), .reset(reset), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_read(hs_read), .hs_data_out(hs_data_out), .hs_ack(hs_ack),
        .hs_busy(hs_busy), .pause_req(pause_req), .paused(paused), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout)
    );

    hiscore_ram_responder #(.RAM_LATENCY(3)) u_dut3 (
        .clock_18(clock_18), .reset(reset), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_read(hs_read), .hs_data_out(d3_dout), .hs_ack(d3_ack),
        .hs_busy(d3_busy), .pause_req(d3_preq), .paused(paused), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_we(cpu_we), .ram_addr(d3_addr), .ram_din(d3_din),
        .ram_we(d3_we), .ram_dout(d3_rdout)
    );

    always @(posedge clock_18) begin
        if (reset) begin
            mem[11'h123] <= 8'hA5;
            mem[11'h010] <= 8'h5A;
        end else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clock_18) begin
        if (reset) mem3[11'h123] <= 8'hA5;
        else if (d3_we) mem3[d3_addr] <= d3_din;
        p3[0] <= mem3[d3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_rdout = p3[2];

    typedef struct {
        logic [3:0]  in;   // rd, wr, paused, cpu_we
        logic [5:0]  ex;   // ack, busy, pause_req, ram_we, hs owns bus, ack of latency-3 unit
        logic [10:0] ha;
        logic [7:0]  hd;
        logic [7:0]  dout;
    } vec_t;
    vec_t tv [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic p, input logic cw);
        @(posedge clock_18);
        #1;
        hs_read  = rd;
        hs_write = wr;
        paused   = p;
        cpu_we   = cw;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int acks;
        // cold read, rows are cycles 10..19
        tv[0]  = '{4'b1000, 6'b000000, 11'h123, 8'h00, 8'h00};
        tv[1]  = '{4'b0000, 6'b011000, 11'h123, 8'h00, 8'h00};
        tv[2]  = '{4'b0000, 6'b011000, 11'h123, 8'h00, 8'h00};
        tv[3]  = '{4'b0010, 6'b011000, 11'h123, 8'h00, 8'h00};
        tv[4]  = '{4'b0010, 6'b011000, 11'h123, 8'h00, 8'h00};
        tv[5]  = '{4'b0010, 6'b011010, 11'h123, 8'h00, 8'h00};
        tv[6]  = '{4'b0010, 6'b011010, 11'h123, 8'h00, 8'h00};
        tv[7]  = '{4'b0010, 6'b111010, 11'h123, 8'h00, 8'hA5};
        tv[8]  = '{4'b0000, 6'b001000, 11'h123, 8'h00, 8'hA5};
        tv[9]  = '{4'b0000, 6'b001001, 11'h123, 8'h00, 8'hA5};
        // cold write with cpu_we held high, rows are cycles 10..18
        tv[10] = '{4'b0101, 6'b000100, 11'h7FF, 8'h3C, 8'hA5};
        tv[11] = '{4'b0001, 6'b011100, 11'h7FF, 8'h3C, 8'hA5};
        tv[12] = '{4'b0001, 6'b011100, 11'h7FF, 8'h3C, 8'hA5};
        tv[13] = '{4'b0011, 6'b011100, 11'h7FF, 8'h3C, 8'hA5};
        tv[14] = '{4'b0011, 6'b011100, 11'h7FF, 8'h3C, 8'hA5};
        tv[15] = '{4'b0011, 6'b011010, 11'h7FF, 8'h3C, 8'hA5};
        tv[16] = '{4'b0011, 6'b011110, 11'h7FF, 8'h3C, 8'hA5};
        tv[17] = '{4'b0011, 6'b111011, 11'h7FF, 8'h3C, 8'hA5};
        tv[18] = '{4'b0001, 6'b001100, 11'h7FF, 8'h3C, 8'hA5};

        reset = 1'b1;
        hs_read = 0; hs_write = 0; paused = 0; cpu_we = 1;
        hs_address = '0; hs_data_in = '0; cpu_addr = CPU_A; cpu_din = 8'h11;
        repeat (3) @(posedge clock_18);
        #1 reset = 1'b0;
        #1;
        chk("reset dout", hs_data_out, 8'h00);
        chk("reset ack", hs_ack, 1'b0);
        chk("reset busy", hs_busy, 1'b0);
        chk("reset preq", pause_req, 1'b0);
        chk("reset ram_we", ram_we, 1'b1);
        chk("reset ram_addr", ram_addr, CPU_A);
        idle(5);

        for (int i = 0; i < 19; i++) begin
            if (i == 10) idle(20);
            hs_address = tv[i].ha;
            hs_data_in = tv[i].hd;
            step(tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
            chk($sformatf("row%0d ack", i), hs_ack, tv[i].ex[5]);
            chk($sformatf("row%0d busy", i), hs_busy, tv[i].ex[4]);
            chk($sformatf("row%0d preq", i), pause_req, tv[i].ex[3]);
            chk($sformatf("row%0d ram_we", i), ram_we, tv[i].ex[2]);
            chk($sformatf("row%0d ram_addr", i), ram_addr, tv[i].ex[1] ? tv[i].ha : CPU_A);
            chk($sformatf("row%0d ack3", i), d3_ack, tv[i].ex[0]);
            chk($sformatf("row%0d dout", i), hs_data_out, tv[i].dout);
            if (i == 9) chk("lat3 read data", d3_dout, 8'hA5);
        end
        idle(2);
        chk("mem 7FF", mem[11'h7FF], 8'h3C);

        // fast path and linger
        idle(20);
        hs_address = 11'h123;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 11; c <= 18; c++) begin
            step(1'b0, 1'b0, c >= 13, 1'b0);
            chk($sformatf("fast c%0d preq", c), pause_req, 1'b1);
            chk($sformatf("fast c%0d ack", c), hs_ack, c == 17);
        end
        hs_address = 11'h010;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("fast c19 preq", pause_req, 1'b1);
        chk("fast c19 busy", hs_busy, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("fast c20 busy", hs_busy, 1'b1);
        chk("fast c20 ram_addr", ram_addr, 11'h010);
        chk("fast c20 ack", hs_ack, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("fast c21 ack", hs_ack, 1'b1);
        chk("fast c21 dout", hs_data_out, 8'h5A);
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("linger +%0d preq", k), pause_req, k <= 16);
            chk($sformatf("linger +%0d ack", k), hs_ack, 1'b0);
        end

        // pause glitch during settle
        idle(20);
        hs_address = 11'h200;
        hs_data_in = 8'h77;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 11; c <= 24; c++) begin
            step(1'b0, 1'b0, c == 13 || c >= 20, 1'b0);
            chk($sformatf("glitch c%0d ram_we", c), ram_we, c == 23);
            chk($sformatf("glitch c%0d ack", c), hs_ack, c == 24);
            if (c == 14 || c == 15) chk($sformatf("glitch c%0d ram_addr", c), ram_addr, CPU_A);
            if (c == 23) chk("glitch c23 ram_addr", ram_addr, 11'h200);
        end
        idle(2);
        chk("mem 200", mem[11'h200], 8'h77);

        // simultaneous strobes, then a strobe while busy
        idle(20);
        hs_address = 11'h300;
        hs_data_in = 8'h99;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        acks = 0;
        for (int c = 11; c <= 30; c++) begin
            step(c == 12, 1'b0, 1'b1, 1'b0);
            if (hs_ack) acks++;
            if (c == 14) chk("simul c14 ram_we", ram_we, 1'b1);
            if (c == 15) chk("simul c15 ack", hs_ack, 1'b1);
        end
        chk("simul ack count", acks, 1);
        chk("mem 300", mem[11'h300], 8'h99);
        chk("simul dout held", hs_data_out, 8'h5A);

        // reset while the latency-3 unit is in READ_WAIT
        idle(20);
        hs_address = 11'h123;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 11; c <= 16; c++) step(1'b0, 1'b0, c >= 13, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst c17 busy3", d3_busy, 1'b1);
        chk("rst c17 ack3", d3_ack, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst c18 ack3", d3_ack, 1'b0);
        chk("rst c18 preq3", d3_preq, 1'b0);
        chk("rst c18 busy3", d3_busy, 1'b0);
        chk("rst c18 addr3", d3_addr, CPU_A);
        chk("rst c18 we3", d3_we, 1'b1);
        chk("rst c18 dout3", d3_dout, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst c19 ack3", d3_ack, 1'b0);
        chk("rst c19 we3", d3_we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hiscore_ram_responder.md
Name: hiscore_ram_responder

Overview:
- Game-side responder for the hiscore engine's RAM port (hs_address / hs_data_in / hs_data_out / hs_write).
- Sits inside the game core between the CPU work-RAM bus and the single-port work RAM.
- Requests a CPU pause, waits for the CPU to halt and the bus to settle, then takes the RAM port for one access and acknowledges.
- Keeps the pause asserted for a linger window so back-to-back hiscore accesses are fast.

Parameters:
- ADDR_W, 11, hiscore/RAM address width.
- DATA_W, 8, data width.
- RAM_LATENCY, 1, RAM read latency in cycles (1..4).
- SETTLE, 2, cycles paused must hold before takeover (1..15).
- LINGER, 16, cycles pause_req is held after an ack, waiting for a follow-up request (0..255; 0 disables).

Ports:
- clock_18  in  1  system clock.
- reset  in  1  synchronous, active-high.
- hs_address  in  ADDR_W  hiscore access address.
- hs_data_in  in  DATA_W  write data from the hiscore engine.
- hs_write  in  1  single-cycle write strobe.
- hs_read  in  1  single-cycle read strobe.
- hs_data_out  out  DATA_W  read data, registered.
- hs_ack  out  1  one-cycle completion pulse.
- hs_busy  out  1  high in every state except IDLE.
- pause_req  out  1  CPU pause request to the pause logic.
- paused  in  1  CPU halted, from the pause logic.
- cpu_addr  in  ADDR_W  CPU RAM address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- ram_addr  out  ADDR_W  to the RAM.
- ram_din  out  DATA_W  to the RAM.
- ram_we  out  1  to the RAM.
- ram_dout  in  DATA_W  from the RAM.

Behaviour:
- Reset (synchronous, active-high, one clock, one reset) has priority over everything:
  - outputs: hs_data_out=0, hs_ack=0, hs_busy=0, pause_req=0;
  - state IDLE, owner=CPU, linger counter=0.
  - Reset mid-access aborts it; ram_we follows cpu_we from the next cycle.
- RAM mux (combinational):
  - owner=CPU: ram_addr/ram_din/ram_we = cpu_addr/cpu_din/cpu_we.
  - owner=HS: latched address/data; ram_we=1 only in a write ACCESS cycle; cpu_we is ignored.
- States: IDLE, WAIT_PAUSE, SETTLE, ACCESS, READ_WAIT, DONE.
- IDLE, on hs_read|hs_write:
  - latch address, data and op; if both strobes are high, write wins.
  - If linger count > 0 and paused=1, go to ACCESS (fast path); otherwise go to WAIT_PAUSE.
- Strobes in any state other than IDLE are ignored; no queue.
- pause_req:
  - set in the cycle after a request is accepted;
  - held through DONE;
  - after DONE, held for LINGER further cycles, then cleared.
  - A request accepted during linger reloads the window and keeps pause_req high continuously.
- WAIT_PAUSE: stays until paused=1, then goes to SETTLE with the counter at SETTLE.
- SETTLE:
  - decrements each cycle; owner switches to HS on the last SETTLE cycle;
  - leaves for ACCESS after exactly SETTLE cycles with paused=1;
  - if paused drops, return to WAIT_PAUSE, owner=CPU, no RAM drive.
- ACCESS, one cycle:
  - write: ram_we=1 at the latched address/data; go to DONE.
  - read: address driven; go to READ_WAIT.
- READ_WAIT:
  - holds the address for RAM_LATENCY−1 further cycles;
  - capture ram_dout into hs_data_out RAM_LATENCY cycles after ACCESS; that capture cycle is DONE.
- DONE: hs_ack=1 for exactly one cycle; owner returns to CPU the next cycle; go to IDLE.
- Timing, with A = ACCESS cycle:
  - write ack at A+1;
  - read ack at A+RAM_LATENCY, with hs_data_out valid in that ack cycle.
  - Cold path: strobe at T, pause_req at T+1, first paused cycle P, ACCESS at P+SETTLE+1.
  - Fast path: ACCESS at T+1.
- hs_data_out holds its last read value until the next read completes; writes do not alter it.
- paused falling during ACCESS or READ_WAIT is not checked. The access completes, because pause_req is still asserted.

Test Plan:
- Cold read (SETTLE=2, RAM_LATENCY=1): RAM[0x123]=0xA5, hs_read at cycle 10, paused rises at 13 → pause_req=1 from 11; ram_addr=0x123 at 16; hs_ack=1 and hs_data_out=0xA5 at 17 only; hs_busy high 11..17.
- Cold write: hs_write at 10 to 0x7FF with data 0x3C, paused from 13, cpu_we=1 throughout → ram_we=1 only at 16 with ram_addr=0x7FF; ack at 17; RAM[0x7FF]=0x3C; cpu_we passed through again from 18.
- Fast path and linger: second hs_read (0x010 → 0x5A) 2 cycles after the first ack with paused still 1 → ACCESS next cycle, ack one later, no pause_req gap. Then no further requests → pause_req falls exactly LINGER=16 cycles after the last ack.
- Pause glitch: paused high at 13, low at 14 (SETTLE) → back to WAIT_PAUSE, ram_we never asserted by HS. Paused high again at 20 → ACCESS at 23.
- Simultaneous strobes: hs_read and hs_write together at IDLE → a write is performed, the read is dropped. A strobe during hs_busy is ignored (no second ack).
- Reset during READ_WAIT (RAM_LATENCY=3) → next cycle: hs_ack=0, pause_req=0, hs_busy=0, ram mux shows cpu_addr/cpu_we.
